// File: rtl/delay_timer_arbiter_if.sv
// Requester and delayer signal bundle for delay_timer_arbiter.
// The slave modport is the arbiter side; the master modport is the client/delayer side.
interface delay_timer_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 12
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_load;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [2:0]        grant_id;
  logic [W-1:0]      tmr_load;
  logic              tmr_start;
  logic              tmr_done;
  logic              wdt_err;

  modport slave (
    input  req, req_load, tmr_done,
    output done, busy, grant_id, tmr_load, tmr_start, wdt_err
  );

  modport master (
    output req, req_load, tmr_done,
    input  done, busy, grant_id, tmr_load, tmr_start, wdt_err
  );
endinterface

// File: rtl/delay_timer_arbiter.sv
// Round-robin arbiter sharing one countdown delayer among NREQ requesters.
// Optional WAIT watchdog enabled by defining DELAY_TIMER_ARBITER_WDT_EN.
module delay_timer_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 12
`ifdef DELAY_TIMER_ARBITER_WDT_EN
  , parameter int unsigned WDT_SLACK = 4
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  delay_timer_arbiter_if.slave bus
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_ACK} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [W-1:0]    load_q, load_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic            tmr_start_q, tmr_start_d;
  logic [W-1:0]    tmr_load_q, tmr_load_d;

  logic            found_c;
  logic [IW-1:0]   pick_c;
  logic [IW:0]     cand_c;

`ifdef DELAY_TIMER_ARBITER_WDT_EN
  logic [W:0]      wdt_cnt_q, wdt_cnt_d;
  logic            wdt_err_q, wdt_err_d;
  logic [W:0]      wdt_nxt_c;
  logic [W:0]      wdt_limit_c;

  assign wdt_nxt_c   = wdt_cnt_q + (W+1)'(1);
  assign wdt_limit_c = (W+1)'(load_q) + (W+1)'(WDT_SLACK);
`endif

  // First asserted request scanning upward from rr_ptr, wrapping at NREQ
  always_comb begin
    found_c = 1'b0;
    pick_c  = '0;
    cand_c  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand_c = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (cand_c >= (IW+1)'(NREQ)) cand_c = cand_c - (IW+1)'(NREQ);
      if (!found_c && bus.req[cand_c[IW-1:0]]) begin
        found_c = 1'b1;
        pick_c  = cand_c[IW-1:0];
      end
    end
  end

  // Next state; outputs are registered from the state being entered
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    load_d      = load_q;
    done_d      = '0;
    busy_d      = 1'b0;
    tmr_start_d = 1'b0;
    tmr_load_d  = '0;
`ifdef DELAY_TIMER_ARBITER_WDT_EN
    wdt_cnt_d   = wdt_cnt_q;
    wdt_err_d   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (found_c) begin
          grant_d = pick_c;
          load_d  = bus.req_load[32'(pick_c) * W +: W];
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = (load_q != '0) ? S_WAIT : S_ACK;
`ifdef DELAY_TIMER_ARBITER_WDT_EN
        wdt_cnt_d = '0;
`endif
      end
      S_WAIT: begin
`ifdef DELAY_TIMER_ARBITER_WDT_EN
        wdt_cnt_d = wdt_nxt_c;
        // a tmr_done coinciding with the limit is a normal completion
        if (bus.tmr_done) begin
          state_d = S_ACK;
        end else if (wdt_nxt_c >= wdt_limit_c) begin
          state_d   = S_ACK;
          wdt_err_d = 1'b1;
        end
`else
        if (bus.tmr_done) state_d = S_ACK;
`endif
      end
      S_ACK: begin
        rr_ptr_d = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + IW'(1);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    tmr_start_d = (state_d == S_LOAD) && (load_d != '0);
    tmr_load_d  = tmr_start_d ? load_d : '0;
    done_d      = (state_d == S_ACK) ? (NREQ'(1) << grant_d) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      load_q      <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      tmr_start_q <= 1'b0;
      tmr_load_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      load_q      <= load_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      tmr_start_q <= tmr_start_d;
      tmr_load_q  <= tmr_load_d;
    end
  end

`ifdef DELAY_TIMER_ARBITER_WDT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdt_cnt_q <= '0;
      wdt_err_q <= 1'b0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
      wdt_err_q <= wdt_err_d;
    end
  end

  assign bus.wdt_err = wdt_err_q;
`else
  assign bus.wdt_err = 1'b0;
`endif

  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = 3'(grant_q);
  assign bus.tmr_load  = tmr_load_q;
  assign bus.tmr_start = tmr_start_q;

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Directed bench for delay_timer_arbiter with a behavioural countdown delayer.
// Watchdog checks are built when DELAY_TIMER_ARBITER_WDT_EN is defined.
module tb_delay_timer_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  delay_timer_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();
  delay_timer_arbiter #(.NREQ(NREQ), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Delayer model: tmr_done pulses L cycles after the tmr_start cycle
  logic       model_en;
  logic       force_done;
  logic [W:0] dly_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          dly_cnt <= '0;
    else if (bus.tmr_start && model_en) dly_cnt <= {1'b0, bus.tmr_load};
    else if (dly_cnt != '0)            dly_cnt <= dly_cnt - 1'b1;
  end
  assign bus.tmr_done = (model_en && dly_cnt == (W+1)'(1)) || force_done;

  int n_cmp, n_err;
  int multi_done, load_leak, wdt_pulses;

  initial begin
    multi_done = 0;
    load_leak  = 0;
    wdt_pulses = 0;
  end

  always @(negedge clk) begin
    if ($countones(bus.done) > 1)                  multi_done <= multi_done + 1;
    if (!bus.tmr_start && bus.tmr_load != '0)      load_leak  <= load_leak + 1;
    if (bus.wdt_err)                               wdt_pulses <= wdt_pulses + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.req = '0;
    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    int idx;
    int load;
    int exp_start;
    int exp_tmr_load;
    int exp_done;
    int exp_lat;
  } vec_t;

  vec_t vecs[5];
  int   exp_order[6];
  int   order[6];
  int   dbits[6];
  int   hold[NREQ];
  logic [NREQ*W-1:0] ld;
  int   starts, st_load, start_k, lat, dval, gid, nd, d3, wv;

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_en   = 1'b1;
    force_done = 1'b0;

    // idx, load, start?, tmr_load, done, cycles from req-sampling IDLE to done
    vecs[0] = '{2, 16,   1, 16,   4, 18};
    vecs[1] = '{1, 0,    0, 0,    2, 2};
    vecs[2] = '{0, 1,    1, 1,    1, 3};
    vecs[3] = '{3, 4095, 1, 4095, 8, 4097};
    vecs[4] = '{2, 5,    1, 5,    4, 7};
    exp_order = '{0, 1, 2, 3, 0, 1};

    // Reset hold with all requesters active
    rst = 1'b0;
    bus.req = '1;
    bus.req_load = {12'h004, 12'h003, 12'h002, 12'h07B};
    repeat (3) @(negedge clk);
    check("rst_done",      32'(bus.done),      0);
    check("rst_busy",      32'(bus.busy),      0);
    check("rst_tmr_start", 32'(bus.tmr_start), 0);
    check("rst_tmr_load",  32'(bus.tmr_load),  0);
    check("rst_grant_id",  32'(bus.grant_id),  0);
    check("rst_wdt_err",   32'(bus.wdt_err),   0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_tmr_start", 32'(bus.tmr_start), 1);
    check("rel_tmr_load",  32'(bus.tmr_load),  32'h07B);
    check("rel_grant_id",  32'(bus.grant_id),  0);
    check("rel_busy",      32'(bus.busy),      1);
    do_reset();

    // Single-request vectors
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < NREQ; j++) ld[j*W +: W] = W'(32'hA00 + j);
      ld[vecs[i].idx*W +: W] = W'(vecs[i].load);
      bus.req_load = ld;
      bus.req = NREQ'(1) << vecs[i].idx;
      starts = 0; st_load = 0; start_k = 0; lat = -1; dval = 0; gid = -1;
      for (int k = 1; k <= 6000; k++) begin
        @(negedge clk);
        if (bus.tmr_start) begin
          starts++;
          st_load = 32'(bus.tmr_load);
          start_k = k;
        end
        if (bus.done != '0) begin
          lat  = k;
          dval = 32'(bus.done);
          gid  = 32'(bus.grant_id);
          break;
        end
      end
      bus.req = '0;
      @(negedge clk);
      check($sformatf("vec%0d_starts",   i), starts,  vecs[i].exp_start);
      check($sformatf("vec%0d_start_at", i), start_k, vecs[i].exp_start);
      check($sformatf("vec%0d_tmr_load", i), st_load, vecs[i].exp_tmr_load);
      check($sformatf("vec%0d_latency",  i), lat,     vecs[i].exp_lat);
      check($sformatf("vec%0d_done",     i), dval,    vecs[i].exp_done);
      check($sformatf("vec%0d_grant",    i), gid,     vecs[i].idx);
      check($sformatf("vec%0d_pulse",    i), 32'(bus.done), 0);
      check($sformatf("vec%0d_idle",     i), 32'(bus.busy), 0);
    end

    // A stray tmr_done while idle must not start anything
    model_en = 1'b0;
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    @(negedge clk);
    check("stray_busy", 32'(bus.busy), 0);
    check("stray_done", 32'(bus.done), 0);
    model_en = 1'b1;
    do_reset();

    // Round-robin with all requesters re-requesting after a one-cycle gap
    bus.req_load = {NREQ{W'(1)}};
    bus.req = '1;
    nd = 0;
    for (int i = 0; i < NREQ; i++) hold[i] = 0;
    for (int i = 0; i < 6; i++) begin order[i] = 99; dbits[i] = 0; end
    for (int c = 0; c < 300 && nd < 6; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (hold[i] > 0) begin
          hold[i]--;
          if (hold[i] == 0) bus.req[i] = 1'b1;
        end
      end
      if (bus.done != '0) begin
        order[nd] = 32'(bus.grant_id);
        dbits[nd] = 32'(bus.done);
        nd++;
        for (int i = 0; i < NREQ; i++) begin
          if (bus.done[i]) begin
            hold[i] = 2;
            bus.req[i] = 1'b0;
          end
        end
      end
    end
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rr_grant%0d", i), order[i], exp_order[i]);
      check($sformatf("rr_done%0d",  i), dbits[i], 1 << exp_order[i]);
    end
    do_reset();

    // Asynchronous reset in the middle of a long WAIT
    bus.req_load = '0;
    bus.req_load[3*W +: W] = W'(100);
    bus.req = 4'b1000;
    starts = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.tmr_start) starts++;
    end
    check("ar_started",  starts, 1);
    check("ar_busy_pre", 32'(bus.busy), 1);
    #2 rst = 1'b0;
    #1;
    check("ar_done",      32'(bus.done),      0);
    check("ar_busy",      32'(bus.busy),      0);
    check("ar_tmr_start", 32'(bus.tmr_start), 0);
    check("ar_tmr_load",  32'(bus.tmr_load),  0);
    check("ar_grant_id",  32'(bus.grant_id),  0);
    d3 = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done != '0) d3++;
    end
    rst = 1'b1;
    @(negedge clk);
    check("ar_re_start", 32'(bus.tmr_start), 1);
    check("ar_re_load",  32'(bus.tmr_load),  100);
    check("ar_re_grant", 32'(bus.grant_id),  3);
    lat = -1; dval = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (bus.done != '0) begin
        lat = k;
        dval = 32'(bus.done);
        if (bus.done[3]) d3 = d3;
        break;
      end
    end
    bus.req = '0;
    @(negedge clk);
    check("ar_re_latency", lat,  101);
    check("ar_re_done",    dval, 8);
    check("ar_no_abandoned_done", d3, 0);

`ifdef DELAY_TIMER_ARBITER_WDT_EN
    // Watchdog: delayer never answers, load 8 with slack 4
    model_en = 1'b0;
    bus.req_load = '0;
    bus.req_load[0 +: W] = W'(8);
    bus.req = 4'b0001;
    start_k = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (bus.tmr_start) begin start_k = k; break; end
    end
    lat = -1; dval = 0; wv = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (bus.done != '0) begin
        lat  = k;
        dval = 32'(bus.done);
        wv   = 32'(bus.wdt_err);
        break;
      end
    end
    bus.req = '0;
    check("wdt_start",   start_k, 1);
    check("wdt_latency", lat,     13);
    check("wdt_done",    dval,    1);
    check("wdt_flag",    wv,      1);
    @(negedge clk);
    check("wdt_idle",    32'(bus.busy),    0);
    check("wdt_clear",   32'(bus.wdt_err), 0);
    model_en = 1'b1;
`else
    // Without the watchdog, WAIT holds until tmr_done
    model_en = 1'b0;
    bus.req_load = '0;
    bus.req_load[0 +: W] = W'(8);
    bus.req = 4'b0001;
    d3 = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done != '0) d3++;
    end
    check("nowdt_no_done", d3, 0);
    check("nowdt_busy",    32'(bus.busy), 1);
    do_reset();
    model_en = 1'b1;
`endif

    @(negedge clk);
    check("mon_done_onehot", multi_done, 0);
    check("mon_load_gated",  load_leak,  0);
`ifdef DELAY_TIMER_ARBITER_WDT_EN
    check("mon_wdt_pulses",  wdt_pulses, 1);
`else
    check("mon_wdt_pulses",  wdt_pulses, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/delay_timer_arbiter.md
Name: delay_timer_arbiter

Overview:
- Round-robin scheduler that shares one countdown delay timer (the existing load/done delayer) among NREQ requesters.
- Each requester asks for a delay of `req_load` cycles. The arbiter loads and starts the timer for the winner, waits for the timer's done, then pulses that requester's done.
- Sits between client FSMs and a single delayer instance in the top level.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 12, delay/load width in bits
- WDT_SLACK, 4, extra cycles tolerated beyond load before the watchdog fires (only with the optional feature)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- req  in  NREQ  per-requester request level; held high until that requester's done pulse
- req_load  in  NREQ*W  packed delay values; slice i = bits [i*W +: W]; sampled only at grant
- done  out  NREQ  one-cycle completion pulse to the granted requester
- busy  out  1  high in any state other than IDLE
- grant_id  out  3  index of the current or most recent grantee
- tmr_load  out  W  load value to the delayer; valid while tmr_start=1, otherwise 0
- tmr_start  out  1  one-cycle start/load strobe to the delayer
- tmr_done  in  1  delayer completion pulse
- wdt_err  out  1  one-cycle watchdog pulse (only with the optional feature; tied 0 otherwise)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst=0), applied immediately regardless of clk:
  - state=IDLE; rr_ptr=0; grant_id=0; latched load=0.
  - done=0, busy=0, tmr_load=0, tmr_start=0, wdt_err=0.
  - Reset mid-operation abandons the grant silently: no done pulse. The external delayer is assumed reset by the same rst.
- FSM states: IDLE, LOAD, WAIT, ACK. All outputs are registered or decoded from state only.
- IDLE:
  - If req is nonzero, select the first asserted bit scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - Latch that index into grant_id and its req_load slice into the load register; go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - If latched load != 0: tmr_start=1 and tmr_load=load for exactly this cycle; go to WAIT.
  - If latched load == 0: no strobe; go directly to ACK (zero-delay request).
- WAIT:
  - Stay until tmr_done=1, then go to ACK.
  - A tmr_done pulse seen in any other state is ignored.
- ACK:
  - done[grant_id]=1 for this cycle only.
  - rr_ptr <= (grant_id+1) mod NREQ; go to IDLE.
- Latency: req rises in cycle t (FSM in IDLE) → tmr_start in t+1 → done pulse in the cycle after tmr_done.
  - Minimum request-to-done with load=0: 2 cycles (LOAD, ACK).
- Requester rules:
  - req must stay high from assertion through its done cycle.
  - req must be low in the cycle after done; otherwise it is treated as a new request.
  - A req dropped before grant is simply not served. A req dropped after grant still completes, and done is still pulsed.
- Fairness: with all NREQ requesting continuously, grants cycle 0,1,2,...,NREQ-1,0. No requester waits more than NREQ-1 other services.
- Simultaneous events: a req change in the same cycle as ACK is evaluated in the following IDLE cycle. Only one grant is outstanding at a time.
- Width rules: load is passed unmodified (W bits, unsigned). Any value 1..2^W-1 is legal.

Optional Feature:
- Macro: DELAY_TIMER_ARBITER_WDT_EN.
- With the macro defined:
  - A W+1 bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches load+WDT_SLACK (computed in W+1 bits, no overflow) without tmr_done, the FSM goes to ACK. The cycle that enters ACK carries wdt_err=1, and ACK pulses done as normal.
  - tmr_done and the watchdog limit arriving in the same cycle count as a normal completion: wdt_err=0.
- Without the macro: no counter; wdt_err is constant 0; WAIT waits indefinitely for tmr_done.

Test Plan:
- Reset hold: rst=0 for 3 cycles with req=4'b1111 → all outputs 0, state IDLE; release rst → grant_id=0, tmr_start=1 with tmr_load=req_load[0] on the next cycle.
- Single request: req[2]=1, req_load[2]=16, delayer model done after 16 cycles → one tmr_start with tmr_load=12'h010, done=4'b0100 for one cycle exactly 1 cycle after tmr_done, busy low afterwards.
- Zero load: req[1]=1, load=0 → no tmr_start; done[1] pulses 2 cycles after req rises.
- Round-robin: all 4 requesters hold req with load=1, each re-requesting after its done → grant order 0,1,2,3,0,1; no done pulse ever has two bits set.
- Async reset mid-WAIT: grant 3 with load=100, assert rst at cycle 20 → outputs clear immediately, no done[3]; after release, a pending req[3] is re-granted with a fresh tmr_start.
- Watchdog (DELAY_TIMER_ARBITER_WDT_EN, WDT_SLACK=4): load=8, tmr_done never asserted → wdt_err and done[grant_id] both pulse 13 cycles after tmr_start; FSM back in IDLE the following cycle.
